// File: rtl/inta_read_responder.sv
// 8259 outbound bus side: sequences INTA vector bytes and returns
// status or poll bytes on CPU reads, with ISR-latch and end-of-ack strobes.
module inta_read_responder #(
    parameter logic [7:0] CALL_OPCODE = 8'hCD
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       CS,
    input  logic       rd_enable,
    input  logic       inta_n,
    input  logic       A1,
    input  logic       mode_8086,
    input  logic       addr_interval4,
    input  logic [7:0] vector_base,
    input  logic [2:0] addr_low,
    input  logic       int_valid,
    input  logic [2:0] int_level,
    input  logic [7:0] irr,
    input  logic [7:0] isr,
    input  logic [7:0] imr,
    input  logic       read_isr_sel,
    input  logic       poll_cmd,
    input  logic       cascade_drive_en,
    input  logic       icw1_write,
    output logic [7:0] data_out,
    output logic       data_out_en,
    output logic       set_isr,
    output logic       ack_done
);

    typedef enum logic [1:0] {IDLE, P1, P2, P3} state_e;

    state_e     state_q, state_d;
    logic       s_inta_q, s_rd_q, s_cs_q, p_inta_q;
    logic [2:0] level_q, level_d;
    logic       poll_armed_q, poll_armed_d;
    logic       poll_rd_q, poll_rd_d;
    logic [7:0] data_out_q, data_out_d;
    logic       en_q, en_d;
    logic       set_isr_q, set_isr_d;
    logic       ack_q, ack_d;

    logic       inta_fall, inta_rise, rd_active;
    logic [7:0] drive_byte;
    logic       drive_ok;

    assign inta_fall = p_inta_q & ~s_inta_q;
    assign inta_rise = ~p_inta_q & s_inta_q;
    assign rd_active = ~s_cs_q & ~s_rd_q & s_inta_q & (state_q == IDLE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s_inta_q     <= 1'b1;
            s_rd_q       <= 1'b1;
            s_cs_q       <= 1'b1;
            p_inta_q     <= 1'b1;
            state_q      <= IDLE;
            level_q      <= 3'd0;
            poll_armed_q <= 1'b0;
            poll_rd_q    <= 1'b0;
            data_out_q   <= 8'h00;
            en_q         <= 1'b0;
            set_isr_q    <= 1'b0;
            ack_q        <= 1'b0;
        end else begin
            s_inta_q     <= inta_n;
            s_rd_q       <= rd_enable;
            s_cs_q       <= CS;
            p_inta_q     <= s_inta_q;
            state_q      <= state_d;
            level_q      <= level_d;
            poll_armed_q <= poll_armed_d;
            poll_rd_q    <= poll_rd_d;
            data_out_q   <= data_out_d;
            en_q         <= en_d;
            set_isr_q    <= set_isr_d;
            ack_q        <= ack_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        level_d      = level_q;
        poll_armed_d = poll_armed_q | poll_cmd;
        poll_rd_d    = poll_rd_q;
        data_out_d   = 8'h00;
        en_d         = 1'b0;
        set_isr_d    = 1'b0;
        ack_d        = 1'b0;
        drive_byte   = 8'h00;
        drive_ok     = 1'b0;

        unique case (state_q)
            IDLE: if (inta_fall) begin
                state_d   = P1;
                level_d   = int_valid ? int_level : 3'd7;
                set_isr_d = int_valid;
            end
            P1: if (inta_fall) state_d = P2;
            P2: begin
                if (mode_8086 && inta_rise) begin
                    state_d = IDLE;
                    ack_d   = 1'b1;
                end else if (!mode_8086 && inta_fall) begin
                    state_d = P3;
                end
            end
            P3: if (inta_rise) begin
                state_d = IDLE;
                ack_d   = 1'b1;
            end
        endcase

        // Byte for the pulse currently in progress (state after this fall)
        unique case (state_d)
            IDLE: ;
            P1: begin
                drive_byte = CALL_OPCODE;
                drive_ok   = ~mode_8086;
            end
            P2: begin
                drive_ok = cascade_drive_en;
                if (mode_8086)
                    drive_byte = {vector_base[7:3], level_q};
                else if (addr_interval4)
                    drive_byte = {addr_low, level_q, 2'b00};
                else
                    drive_byte = {addr_low[2:1], level_q, 3'b000};
            end
            P3: begin
                drive_byte = vector_base;
                drive_ok   = cascade_drive_en;
            end
        endcase

        if (state_d != IDLE) begin
            if (!s_inta_q && drive_ok) begin
                en_d       = 1'b1;
                data_out_d = drive_byte;
            end
        end else if (rd_active) begin
            en_d = 1'b1;
            if (poll_armed_q) begin
                data_out_d = {int_valid, 4'b0000, int_level};
                set_isr_d  = int_valid & ~poll_rd_q;
                poll_rd_d  = 1'b1;
            end else begin
                data_out_d = A1 ? imr : (read_isr_sel ? isr : irr);
            end
        end

        if (s_rd_q) begin
            poll_rd_d = 1'b0;
            if (poll_rd_q) begin
                ack_d        = 1'b1;
                poll_armed_d = poll_cmd;
            end
        end

        if (icw1_write) begin
            state_d      = IDLE;
            poll_armed_d = 1'b0;
            poll_rd_d    = 1'b0;
            data_out_d   = 8'h00;
            en_d         = 1'b0;
            set_isr_d    = 1'b0;
            ack_d        = 1'b0;
        end
    end

    assign data_out    = data_out_q;
    assign data_out_en = en_q;
    assign set_isr     = set_isr_q;
    assign ack_done    = ack_q;

endmodule

// File: tb/tb_inta_read_responder.sv
// Scoreboard bench for inta_read_responder: a transaction-level model
// queues expected bus events and a negedge monitor consumes them.
module tb_inta_read_responder;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       CS = 1'b1, rd_enable = 1'b1, inta_n = 1'b1, A1 = 1'b0;
    logic       mode_8086 = 1'b1, addr_interval4 = 1'b0;
    logic [7:0] vector_base = 8'h00;
    logic [2:0] addr_low = 3'd0;
    logic       int_valid = 1'b0;
    logic [2:0] int_level = 3'd0;
    logic [7:0] irr = 8'h00, isr = 8'h00, imr = 8'h00;
    logic       read_isr_sel = 1'b0, poll_cmd = 1'b0;
    logic       cascade_drive_en = 1'b1, icw1_write = 1'b0;
    logic [7:0] data_out;
    logic       data_out_en, set_isr, ack_done;

    always #5 clk = ~clk;

    inta_read_responder #(.CALL_OPCODE(8'hCD)) dut (
        .clk(clk), .reset_n(reset_n), .CS(CS), .rd_enable(rd_enable),
        .inta_n(inta_n), .A1(A1), .mode_8086(mode_8086),
        .addr_interval4(addr_interval4), .vector_base(vector_base),
        .addr_low(addr_low), .int_valid(int_valid), .int_level(int_level),
        .irr(irr), .isr(isr), .imr(imr), .read_isr_sel(read_isr_sel),
        .poll_cmd(poll_cmd), .cascade_drive_en(cascade_drive_en),
        .icw1_write(icw1_write), .data_out(data_out),
        .data_out_en(data_out_en), .set_isr(set_isr), .ack_done(ack_done)
    );

    typedef enum logic [1:0] {EV_SET, EV_DRV, EV_ACK} ev_kind_e;
    typedef struct packed {
        ev_kind_e   kind;
        logic [7:0] data;
    } ev_t;

    ev_t        exp_q[$];
    int         vectors = 0;
    int         miscompares = 0;
    bit         poll_armed_m = 1'b0;
    logic       en_prev = 1'b0;
    logic [7:0] hold = 8'h00;

    task automatic expect_ev(input ev_kind_e k, input logic [7:0] d);
        ev_t e;
        e.kind = k;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic see(input ev_kind_e k, input logic [7:0] d);
        ev_t e;
        ev_kind_e ek;
        vectors++;
        if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_event: got %s %h, expected none", k.name(), d);
        end else begin
            e = exp_q.pop_front();
            ek = e.kind;
            if (ek !== k || e.data !== d) begin
                miscompares++;
                $display("FAIL event: got %s %h, expected %s %h",
                         k.name(), d, ek.name(), e.data);
            end
        end
    endtask

    always @(negedge clk) begin
        if (reset_n) begin
            if (set_isr) see(EV_SET, 8'h00);
            if (data_out_en && !en_prev) begin
                see(EV_DRV, data_out);
                hold = data_out;
            end else if (data_out_en) begin
                vectors++;
                if (data_out !== hold) begin
                    miscompares++;
                    $display("FAIL drive_stable: got %h, expected %h", data_out, hold);
                end
            end
            if (ack_done) see(EV_ACK, 8'h00);
        end
        en_prev = data_out_en;
    end

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [7:0] vec86(logic [7:0] vb, logic [2:0] l);
        return (vb & 8'hF8) + 8'(l);
    endfunction

    function automatic logic [7:0] vec80(bit i4, logic [2:0] al, logic [2:0] l);
        if (i4) return 8'(al * 32 + l * 4);
        return 8'((al / 2) * 64 + l * 8);
    endfunction

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL drain_timeout: %0d events pending, expected 0", exp_q.size());
            exp_q.delete();
        end
        repeat (2) @(posedge clk);
    endtask

    task automatic inta_pulse();
        @(posedge clk); #1 inta_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 inta_n = 1'b1;
        repeat (3) @(posedge clk);
    endtask

    task automatic run_inta(input bit m86, input bit i4, input logic [7:0] vb,
                            input logic [2:0] al, input bit vld,
                            input logic [2:0] lvl, input bit casc);
        logic [2:0] le;
        le = vld ? lvl : 3'd7;
        mode_8086 = m86; addr_interval4 = i4; vector_base = vb;
        addr_low = al; int_valid = vld; int_level = lvl;
        cascade_drive_en = casc;
        if (vld) expect_ev(EV_SET, 8'h00);
        if (!m86) expect_ev(EV_DRV, 8'hCD);
        inta_pulse();
        int_level = 3'($urandom);
        int_valid = 1'($urandom);
        if (m86) begin
            if (casc) expect_ev(EV_DRV, vec86(vb, le));
            expect_ev(EV_ACK, 8'h00);
            inta_pulse();
        end else begin
            if (casc) expect_ev(EV_DRV, vec80(i4, al, le));
            inta_pulse();
            if (casc) expect_ev(EV_DRV, vb);
            expect_ev(EV_ACK, 8'h00);
            inta_pulse();
        end
        drain();
    endtask

    task automatic do_read(input bit cs, input bit a1, input bit sel,
                           input logic [7:0] r_irr, input logic [7:0] r_isr,
                           input logic [7:0] r_imr, input bit vld,
                           input logic [2:0] lvl);
        A1 = a1; read_isr_sel = sel; irr = r_irr; isr = r_isr; imr = r_imr;
        int_valid = vld; int_level = lvl;
        if (!cs) begin
            if (poll_armed_m) begin
                if (vld) expect_ev(EV_SET, 8'h00);
                expect_ev(EV_DRV, {vld, 4'b0000, lvl});
                expect_ev(EV_ACK, 8'h00);
                poll_armed_m = 1'b0;
            end else begin
                expect_ev(EV_DRV, a1 ? r_imr : (sel ? r_isr : r_irr));
            end
        end
        @(posedge clk); #1 CS = cs; rd_enable = 1'b0;
        repeat (4) @(posedge clk);
        #1 rd_enable = 1'b1; CS = 1'b1;
        repeat (3) @(posedge clk);
        drain();
    endtask

    task automatic arm_poll();
        @(posedge clk); #1 poll_cmd = 1'b1;
        @(posedge clk); #1 poll_cmd = 1'b0;
        poll_armed_m = 1'b1;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("reset_data", data_out, 8'h00);
        chk("reset_en", 8'(data_out_en), 8'h00);
        chk("reset_set_isr", 8'(set_isr), 8'h00);
        chk("reset_ack", 8'(ack_done), 8'h00);
        reset_n = 1'b1;
        repeat (2) @(posedge clk);

        run_inta(1, 0, 8'h40, 3'd0, 1, 3'd3, 1);
        run_inta(0, 1, 8'h12, 3'b101, 1, 3'd6, 1);
        run_inta(1, 0, 8'h40, 3'd0, 0, 3'd2, 1);
        run_inta(0, 0, 8'h9C, 3'b110, 0, 3'd1, 1);

        do_read(0, 1, 0, 8'h0F, 8'h20, 8'hA5, 0, 3'd0);
        do_read(0, 0, 0, 8'h0F, 8'h20, 8'hA5, 0, 3'd0);
        do_read(0, 0, 1, 8'h0F, 8'h20, 8'hA5, 0, 3'd0);

        // Enable release timing relative to the read strobe
        A1 = 1'b1; imr = 8'hA5;
        expect_ev(EV_DRV, 8'hA5);
        @(posedge clk); #1 CS = 1'b0; rd_enable = 1'b0;
        repeat (4) @(posedge clk);
        #1 rd_enable = 1'b1;
        @(posedge clk); #1 chk("rd_en_hold_1clk", 8'(data_out_en), 8'h01);
        @(posedge clk); #1 chk("rd_en_off_2clk", 8'(data_out_en), 8'h00);
        CS = 1'b1;
        drain();

        arm_poll();
        do_read(0, 0, 0, 8'h0F, 8'h20, 8'hA5, 1, 3'd5);
        do_read(0, 0, 0, 8'h0F, 8'h20, 8'hA5, 1, 3'd5);

        // A read overlapping INTA is ignored and leaves the poll armed
        arm_poll();
        mode_8086 = 1'b1; vector_base = 8'h28; int_valid = 1'b1; int_level = 3'd4;
        cascade_drive_en = 1'b1;
        expect_ev(EV_SET, 8'h00);
        @(posedge clk); #1 CS = 1'b0; rd_enable = 1'b0; inta_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rd_enable = 1'b1; CS = 1'b1; inta_n = 1'b1;
        repeat (3) @(posedge clk);
        expect_ev(EV_DRV, 8'h2C);
        expect_ev(EV_ACK, 8'h00);
        inta_pulse();
        drain();
        do_read(0, 0, 0, 8'h33, 8'h00, 8'h00, 0, 3'd2);

        // Reset during 8080 P2, then a fresh sequence starts at P1
        mode_8086 = 1'b0; addr_interval4 = 1'b0; addr_low = 3'b011;
        vector_base = 8'h9C; int_valid = 1'b1; int_level = 3'd2;
        expect_ev(EV_SET, 8'h00);
        expect_ev(EV_DRV, 8'hCD);
        inta_pulse();
        expect_ev(EV_DRV, vec80(0, 3'b011, 3'd2));
        @(posedge clk); #1 inta_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 chk("p2_drive_before_reset", 8'(data_out_en), 8'h01);
        reset_n = 1'b0;
        #1;
        chk("abort_reset_data", data_out, 8'h00);
        chk("abort_reset_en", 8'(data_out_en), 8'h00);
        chk("abort_reset_set_isr", 8'(set_isr), 8'h00);
        chk("abort_reset_ack", 8'(ack_done), 8'h00);
        @(posedge clk); #1 inta_n = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        poll_armed_m = 1'b0;
        drain();
        run_inta(0, 1, 8'h55, 3'b010, 1, 3'd7, 1);

        // icw1_write mid-P2: no ack, poll disarmed
        arm_poll();
        mode_8086 = 1'b1; vector_base = 8'hB0; int_valid = 1'b1; int_level = 3'd1;
        expect_ev(EV_SET, 8'h00);
        inta_pulse();
        expect_ev(EV_DRV, 8'hB1);
        @(posedge clk); #1 inta_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 icw1_write = 1'b1;
        @(posedge clk); #1 icw1_write = 1'b0;
        chk("icw1_en_off", 8'(data_out_en), 8'h00);
        repeat (2) @(posedge clk);
        #1 inta_n = 1'b1;
        repeat (4) @(posedge clk);
        poll_armed_m = 1'b0;
        drain();
        do_read(0, 1, 0, 8'h00, 8'h00, 8'h5A, 1, 3'd3);
        run_inta(1, 0, 8'hC8, 3'd0, 1, 3'd6, 1);

        run_inta(1, 0, 8'h78, 3'd0, 1, 3'd2, 0);
        run_inta(0, 0, 8'h31, 3'b100, 1, 3'd4, 0);

        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(0, 4))
                0: run_inta(1, 1'($urandom), 8'($urandom), 3'($urandom),
                            1'($urandom), 3'($urandom), ($urandom_range(0, 3) != 0));
                1: run_inta(0, 1'($urandom), 8'($urandom), 3'($urandom),
                            1'($urandom), 3'($urandom), ($urandom_range(0, 3) != 0));
                2: do_read(0, 1'($urandom), 1'($urandom), 8'($urandom),
                           8'($urandom), 8'($urandom), 1'($urandom), 3'($urandom));
                3: do_read(1'($urandom), 1'($urandom), 1'($urandom), 8'($urandom),
                           8'($urandom), 8'($urandom), 1'($urandom), 3'($urandom));
                default: arm_poll();
            endcase
        end
        do_read(0, 0, 0, 8'h11, 8'h22, 8'h44, 1, 3'd6);

        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL final_queue: %0d pending, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/inta_read_responder.md
Name: inta_read_responder

Overview:
- Outbound half of the 8259 CPU bus interface: drives the bidirectional data bus during CPU reads.
- The inbound write decoder turns CPU writes into ICW/OCW strobes. This block sequences INTA pulses to deliver the interrupt vector (8086 or 8080 format) and returns status bytes (IRR/ISR/IMR/poll word) on RD cycles.
- Its strobes tell the priority logic when to latch ISR and when the acknowledge sequence ends.

Parameters:
- CALL_OPCODE, 8'hCD, byte driven on the first INTA pulse in 8080 mode.

Ports:
- clk  input  1  system clock, rising edge
- reset_n  input  1  asynchronous active-low reset
- CS  input  1  chip select, active low
- rd_enable  input  1  read strobe, active low
- inta_n  input  1  interrupt acknowledge, active low
- A1  input  1  register address bit
- mode_8086  input  1  1 = 8086 two-pulse INTA, 0 = 8080 three-pulse
- addr_interval4  input  1  8080 only: 1 = interval 4, 0 = interval 8
- vector_base  input  8  ICW2 byte; 8080 high-address byte / 8086 T7-T3
- addr_low  input  3  ICW1 A7-A5 (8080 low address)
- int_valid  input  1  a pending unmasked request exists
- int_level  input  3  highest-priority pending level
- irr, isr, imr  input  8 each  status registers
- read_isr_sel  input  1  OCW3 RIS: 1 = ISR, 0 = IRR
- poll_cmd  input  1  one-cycle pulse: OCW3 poll issued
- cascade_drive_en  input  1  0 = this chip must not drive vector bytes
- icw1_write  input  1  one-cycle pulse: initialization restarts
- data_out  output  8  byte to the data bus
- data_out_en  output  1  bus driver enable
- set_isr  output  1  one-cycle: latch int_level into ISR
- ack_done  output  1  one-cycle: acknowledge/poll sequence finished (AEOI hook)

Behaviour:
- **Sampling.** inta_n, rd_enable and CS are registered on every clk edge (s_inta, s_rd, s_cs).
  - Fall/rise events are derived from the current vs previous sampled value.
  - All outputs are registered from the sampled values, so a pin change becomes visible at the outputs 2 rising edges later.
- **Reset.** While reset_n is low: state = IDLE, data_out = 8'h00, data_out_en = 0, set_isr = 0, ack_done = 0, poll_armed = 0, latched level = 0.
- **INTA FSM states:** IDLE, P1, P2, P3.
  - IDLE -> P1 on an inta fall. On that fall:
    - Latch int_level, or 3'd7 if int_valid = 0 (spurious IR7).
    - Pulse set_isr only if int_valid = 1.
  - P1 -> P2 on the next fall; P2 -> P3 on the next fall (8080 only).
  - Sequence end: in 8086 mode the P2 rise returns to IDLE; in 8080 mode the P3 rise returns to IDLE. ack_done pulses one cycle on that rise.
- **8086 bytes:**
  - P1: data_out_en = 0.
  - P2: drive {vector_base[7:3], level}.
- **8080 bytes:**
  - P1: drive CALL_OPCODE.
  - P2, interval 4: drive {addr_low[2:0], level, 2'b00}.
  - P2, interval 8: drive {addr_low[2:1], level, 3'b000}.
  - P3: drive vector_base.
- **Drive window.** data_out_en = 1 only while s_inta is low within a drive state; it drops with s_inta high between pulses.
  - Vector bytes (8086 P2, 8080 P2/P3) additionally require cascade_drive_en = 1. The CALL byte ignores it.
  - Pulse counting continues when drive is suppressed.
- **Status reads.** Active when s_cs = 0, s_rd = 0, s_inta = 1 and state = IDLE.
  - If poll_armed: drive {int_valid, 4'b0000, int_level}. On the read fall pulse set_isr if int_valid. On the read rise clear poll_armed and pulse ack_done.
  - Otherwise A1 = 1 drives imr; A1 = 0 drives isr if read_isr_sel, else irr.
  - Data tracks the inputs each cycle while the read is active.
- **poll_cmd** sets poll_armed. It is held until consumed, icw1_write or reset.
- **Priority.** INTA beats RD: any read while inta is low or state != IDLE returns data_out_en = 0, with no poll consumption.
- **icw1_write** in any state: state = IDLE, poll_armed = 0, data_out_en = 0 next cycle, no ack_done.
- **Mid-sequence int_level changes** are ignored; the level latched at P1 is used.
- inta fall and poll_cmd in the same cycle: both take effect; poll stays armed for a later read.

Test Plan:
- 8086, vector_base = 8'h40, int_valid = 1, int_level = 3 -> two INTA pulses:
  - set_isr one cycle after pulse 1.
  - No drive during pulse 1.
  - Pulse 2 drives 8'h43.
  - ack_done on the pulse-2 rise.
- 8080, addr_interval4 = 1, addr_low = 3'b101, vector_base = 8'h12, level 6 -> three pulses drive 8'hCD, 8'hB8, 8'h12; ack_done after pulse 3.
- 8086, int_valid = 0 -> pulse 2 drives {vector_base[7:3], 3'b111}; set_isr never asserts.
- Status reads:
  - A1 = 1 returns imr = 8'hA5.
  - A1 = 0 with read_isr_sel = 0 returns irr = 8'h0F; with read_isr_sel = 1 returns isr = 8'h20.
  - data_out_en falls 2 clocks after rd_enable rises.
- poll_cmd, then read with int_valid = 1, level 5 -> 8'h85, set_isr and ack_done pulse. The following read returns irr.
- Abort cases:
  - reset_n asserted during 8080 P2 -> all outputs 0 immediately; next INTA restarts at P1.
  - icw1_write in P2 -> IDLE, no ack_done.
  - cascade_drive_en = 0 -> pulses counted, data_out_en stays 0.
